// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Ports: clk/reset; NR_READ read ports (rd_en/rd_addr -> rd_data/rd_busy);
// NR_WRITE write ports (wr_en/wr_addr/wr_data); issue (iss_en/iss_addr);
// flush; busy_any = OR of stored busy bits.
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int REG_WIDTH  = 5,
    parameter int NR_READ    = 4,
    parameter int NR_WRITE   = 2,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NR_READ-1:0]             rd_en,
    input  logic [NR_READ*REG_WIDTH-1:0]   rd_addr,
    output logic [NR_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [NR_READ-1:0]             rd_busy,
    input  logic [NR_WRITE-1:0]            wr_en,
    input  logic [NR_WRITE*REG_WIDTH-1:0]  wr_addr,
    input  logic [NR_WRITE*DATA_WIDTH-1:0] wr_data,
    input  logic                           iss_en,
    input  logic [REG_WIDTH-1:0]           iss_addr,
    input  logic                           flush,
    output logic                           busy_any
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic [REG_NUM-1:0]    busy;
    logic [REG_NUM-1:0]    busy_nxt;

    // Clears first, then issue set, then flush: later assignments win,
    // so set beats a same-cycle clear and flush beats everything.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NR_WRITE; w++) begin
            if (wr_en[w] && wr_addr[w*REG_WIDTH +: REG_WIDTH] != '0)
                busy_nxt[wr_addr[w*REG_WIDTH +: REG_WIDTH]] = 1'b0;
        end
        if (iss_en && iss_addr != '0)
            busy_nxt[iss_addr] = 1'b1;
        if (flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    // Later ports override earlier ones on an address conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REG_NUM; r++)
                regs[r] <= '0;
            busy <= '0;
        end else begin
            for (int w = 0; w < NR_WRITE; w++) begin
                if (wr_en[w] && wr_addr[w*REG_WIDTH +: REG_WIDTH] != '0)
                    regs[wr_addr[w*REG_WIDTH +: REG_WIDTH]]
                        <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NR_READ; i++) begin
            if (rd_en[i] && rd_addr[i*REG_WIDTH +: REG_WIDTH] != '0) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                    regs[rd_addr[i*REG_WIDTH +: REG_WIDTH]];
                rd_busy[i] = busy[rd_addr[i*REG_WIDTH +: REG_WIDTH]];
                if (BYPASS) begin
                    // Highest-index matching writer is forwarded last.
                    for (int w = 0; w < NR_WRITE; w++) begin
                        if (wr_en[w] && wr_addr[w*REG_WIDTH +: REG_WIDTH]
                                == rd_addr[i*REG_WIDTH +: REG_WIDTH]) begin
                            rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                                wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                            rd_busy[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign busy_any = |busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb.
// Runs a BYPASS=1 and a BYPASS=0 instance side by side on shared inputs.
module tb_regfile_mp_sb;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   rd_en;
    logic [19:0]  rd_addr;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         iss_en;
    logic [4:0]   iss_addr;
    logic         flush;

    logic [127:0] rd_data_b, rd_data_n;
    logic [3:0]   rd_busy_b, rd_busy_n;
    logic         busy_any_b, busy_any_n;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .busy_any(busy_any_b)
    );

    regfile_mp_sb #(.BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .flush(flush), .busy_any(busy_any_n)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] db(input int p);
        return rd_data_b[p*32 +: 32];
    endfunction

    function automatic logic [31:0] dn(input int p);
        return rd_data_n[p*32 +: 32];
    endfunction

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a,
                      input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_en = 1'b1;
        iss_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // reset state
        for (int p = 0; p < 4; p++) rd(p, 5'(p + 1));
        #1;
        for (int p = 0; p < 4; p++) chk("rst_data", db(p), 32'h0);
        chk("rst_busy", 32'(rd_busy_b), 32'h0);
        chk("rst_any", 32'(busy_any_b), 32'h0);

        // plain write, r0 ignored
        idle();
        wr(0, 5'd5, 32'hDEADBEEF);
        wr(1, 5'd0, 32'h00001234);
        tick();
        idle();
        rd(0, 5'd5); rd(1, 5'd0);
        #1;
        chk("wr_r5", db(0), 32'hDEADBEEF);
        chk("wr_r0", db(1), 32'h0);
        chk("wr_r5_nb", dn(0), 32'hDEADBEEF);
        rd_en[0] = 1'b0;
        #1;
        chk("rd_dis", db(0), 32'h0);

        // same-cycle bypass
        idle();
        wr(1, 5'd7, 32'hA5A5A5A5);
        rd(2, 5'd7);
        #1;
        chk("byp_r7", db(2), 32'hA5A5A5A5);
        chk("nobyp_r7", dn(2), 32'h0);
        tick();

        // same-address conflict
        idle();
        wr(0, 5'd9, 32'h11);
        wr(1, 5'd9, 32'h22);
        rd(0, 5'd9);
        #1;
        chk("conf_byp", db(0), 32'h22);
        chk("conf_nob", dn(0), 32'h0);
        tick();
        idle();
        rd(0, 5'd9);
        #1;
        chk("conf_r9", db(0), 32'h22);
        chk("conf_r9_nb", dn(0), 32'h22);

        // scoreboard set then clear
        idle();
        iss(5'd3);
        tick();
        idle();
        rd(0, 5'd3);
        #1;
        chk("iss_busy", 32'(rd_busy_b[0]), 32'h1);
        chk("iss_any", 32'(busy_any_b), 32'h1);
        wr(0, 5'd3, 32'h55);
        #1;
        chk("wb_busy_b", 32'(rd_busy_b[0]), 32'h0);
        chk("wb_data_b", db(0), 32'h55);
        chk("wb_busy_n", 32'(rd_busy_n[0]), 32'h1);
        chk("wb_data_n", dn(0), 32'h0);
        chk("wb_any_same", 32'(busy_any_b), 32'h1);
        tick();
        idle();
        rd(0, 5'd3);
        #1;
        chk("wb_clr", 32'(rd_busy_b[0]), 32'h0);
        chk("wb_clr_n", 32'(rd_busy_n[0]), 32'h0);
        chk("wb_any", 32'(busy_any_b), 32'h0);

        // issue wins over same-cycle writeback
        idle();
        iss(5'd3);
        wr(1, 5'd3, 32'h77);
        tick();
        idle();
        rd(0, 5'd3);
        #1;
        chk("iss_wb_busy", 32'(rd_busy_b[0]), 32'h1);
        chk("iss_wb_data", db(0), 32'h77);

        // issue on r0 ignored
        idle();
        iss(5'd0);
        tick();
        idle();
        rd(0, 5'd0);
        #1;
        chk("iss_r0", 32'(rd_busy_b[0]), 32'h0);

        // flush beats issue
        idle();
        iss(5'd4);
        tick();
        idle();
        iss(5'd6);
        tick();
        idle();
        flush = 1'b1;
        iss(5'd8);
        rd(0, 5'd4); rd(1, 5'd6); rd(2, 5'd8); rd(3, 5'd3);
        #1;
        chk("pre_flush", 32'(rd_busy_b), 32'hB);
        tick();
        idle();
        rd(0, 5'd4); rd(1, 5'd6); rd(2, 5'd8); rd(3, 5'd3);
        #1;
        chk("flush_busy", 32'(rd_busy_b), 32'h0);
        chk("flush_any", 32'(busy_any_b), 32'h0);
        chk("flush_any_n", 32'(busy_any_n), 32'h0);

        // reset mid-sequence
        idle();
        iss(5'd10);
        tick();
        idle();
        iss(5'd11);
        wr(0, 5'd12, 32'h99);
        tick();
        idle();
        rd(0, 5'd10); rd(1, 5'd11); rd(2, 5'd12); rd(3, 5'd5);
        #1;
        chk("mid_busy", 32'(rd_busy_b), 32'h3);
        chk("mid_r12", db(2), 32'h99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_busy", 32'(rd_busy_b), 32'h0);
        chk("rst2_any", 32'(busy_any_b), 32'h0);
        chk("rst2_r12", db(2), 32'h0);
        chk("rst2_r5", db(3), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
